// File: rtl/spi_sram_arbiter_pkg.sv
// spi_con: shared constants and types for the SPI SRAM arbiter.
//   OPC_READ / OPC_WRITE  byte-mode SRAM opcodes
//   SPI_ADDRBITS          address bits sent on the wire
//   FRAMEBITS             opcode + address + data bits per transaction
//   state_t               arbiter states
//   port_t                requester identity
package spi_con;

  localparam logic [7:0] OPC_READ     = 8'h03;
  localparam logic [7:0] OPC_WRITE    = 8'h02;
  localparam int         SPI_ADDRBITS = 24;
  localparam int         FRAMEBITS    = 8 + SPI_ADDRBITS + 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  typedef enum logic {
    RD,
    WR
  } port_t;

  function automatic logic [FRAMEBITS-1:0] make_frame(
    input logic [7:0]              opc,
    input logic [SPI_ADDRBITS-1:0] addr,
    input logic [7:0]              data
  );
    return {opc, addr, data};
  endfunction

endpackage

// File: rtl/spi_sram_arbiter_shift_engine.sv
// spi_shift_engine: serialises one 40-bit frame onto the SPI pins (mode 0,
// sck = clk/2) and collects the last 8 bits from so on read transactions.
//   clk_i, rst_ni  clock, async active-low reset
//   start_i        load frame_i and begin shifting (ignored while active)
//   is_read_i      sample so during the data byte of this frame
//   frame_i        frame to send, MSB first
//   so_i           serial data from the SRAM
//   cs_o/sck_o/si_o  registered SPI pins
//   rx_o           last byte sampled from so (held between reads)
//   done_o         high in the final cycle; the frame ends at the coming edge
module spi_shift_engine
  import spi_con::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 is_read_i,
  input  logic [FRAMEBITS-1:0] frame_i,
  input  logic                 so_i,
  output logic                 cs_o,
  output logic                 sck_o,
  output logic                 si_o,
  output logic [7:0]           rx_o,
  output logic                 done_o
);

  localparam int BIT_W = $clog2(FRAMEBITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAMEBITS - 1);
  localparam logic [BIT_W-1:0] RX_FIRST = BIT_W'(FRAMEBITS - 8);

  logic [FRAMEBITS-1:0] frame_q;
  logic [BIT_W-1:0]     bit_q;
  logic                 phase_q;
  logic                 active_q;
  logic                 read_q;
  logic                 cs_q;
  logic                 sck_q;
  logic                 si_q;
  logic [7:0]           rx_q;

  assign done_o = active_q && phase_q && (bit_q == LAST_BIT);

  // frame_q holds the bits not yet placed on si; si_q carries the current bit
  // so it is already valid in the first cycle after the start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q  <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
      read_q   <= 1'b0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      si_q     <= 1'b0;
      rx_q     <= '0;
    end else if (!active_q) begin
      if (start_i) begin
        active_q <= 1'b1;
        read_q   <= is_read_i;
        cs_q     <= 1'b0;
        sck_q    <= 1'b0;
        si_q     <= frame_i[FRAMEBITS-1];
        frame_q  <= {frame_i[FRAMEBITS-2:0], 1'b0};
        bit_q    <= '0;
        phase_q  <= 1'b0;
      end
    end else if (!phase_q) begin
      sck_q   <= 1'b1;
      phase_q <= 1'b1;
    end else begin
      // SRAM drives so after sck falls; it is stable by the end of the high phase.
      if (read_q && (bit_q >= RX_FIRST)) begin
        rx_q <= {rx_q[6:0], so_i};
      end
      phase_q <= 1'b0;
      sck_q   <= 1'b0;
      if (bit_q == LAST_BIT) begin
        active_q <= 1'b0;
        cs_q     <= 1'b1;
        si_q     <= 1'b0;
      end else begin
        si_q    <= frame_q[FRAMEBITS-1];
        frame_q <= {frame_q[FRAMEBITS-2:0], 1'b0};
        bit_q   <= bit_q + BIT_W'(1);
      end
    end
  end

  assign cs_o  = cs_q;
  assign sck_o = sck_q;
  assign si_o  = si_q;
  assign rx_o  = rx_q;

endmodule

// File: rtl/spi_sram_arbiter.sv
// spi_sram_arbiter: round-robin owner of the single SPI SRAM, shared by the
// video read port and the pixel write port. One byte-mode transaction at a time.
//   clk_i, rst_ni                    clock, async active-low reset
//   rd_req_i, rd_addr_i              read request / address (held until rd_gnt_o)
//   rd_gnt_o, rd_valid_o, rd_data_o  read accept pulse, data-valid pulse, held data
//   wr_req_i, wr_addr_i, wr_data_i   write request / address / byte (held until wr_gnt_o)
//   wr_gnt_o, wr_done_o              write accept pulse, write-finished pulse
//   busy_o                           not IDLE
//   cs_o, sck_o, si_o, so_i          SRAM SPI pins
//
// state | meaning
// IDLE  | bus free, grant a pending request
// SHIFT | frame on the wire, cs low for 80 cycles
// GAP   | cs high recovery, CS_GAP cycles before IDLE
module spi_sram_arbiter
  import spi_con::*;
#(
  parameter int ADDRESSBITS = 19,
  parameter int CS_GAP      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rd_req_i,
  input  logic [ADDRESSBITS-1:0] rd_addr_i,
  output logic                   rd_gnt_o,
  output logic                   rd_valid_o,
  output logic [7:0]             rd_data_o,
  input  logic                   wr_req_i,
  input  logic [ADDRESSBITS-1:0] wr_addr_i,
  input  logic [7:0]             wr_data_i,
  output logic                   wr_gnt_o,
  output logic                   wr_done_o,
  output logic                   busy_o,
  output logic                   cs_o,
  output logic                   sck_o,
  output logic                   si_o,
  input  logic                   so_i
);

  if (ADDRESSBITS > SPI_ADDRBITS) begin : g_addr_chk
    $error("ADDRESSBITS must not exceed SPI_ADDRBITS");
  end
  if (CS_GAP < 1) begin : g_gap_chk
    $error("CS_GAP must be at least 1");
  end

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  // The SHIFT->GAP edge is also the edge cs rises, so GAP spans CS_GAP cycles of cs high.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

  state_t               state_q, state_d;
  port_t                last_q, last_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 rd_gnt_q, rd_gnt_d;
  logic                 wr_gnt_q, wr_gnt_d;
  logic                 busy_q;
  logic                 fin_q;
  logic                 rd_valid_q;
  logic                 wr_done_q;
  logic [7:0]           rd_data_q;

  logic                 eng_start;
  logic                 eng_is_read;
  logic [FRAMEBITS-1:0] eng_frame;
  logic                 eng_done;
  logic [7:0]           eng_rx;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gap_d       = gap_q;
    rd_gnt_d    = 1'b0;
    wr_gnt_d    = 1'b0;
    eng_start   = 1'b0;
    eng_is_read = 1'b0;
    eng_frame   = '0;
    case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (rd_req_i && (!wr_req_i || last_q == WR)) begin
          rd_gnt_d    = 1'b1;
          last_d      = RD;
          eng_start   = 1'b1;
          eng_is_read = 1'b1;
          eng_frame   = make_frame(OPC_READ, SPI_ADDRBITS'(rd_addr_i), 8'h00);
          state_d     = SHIFT;
        end else if (wr_req_i) begin
          wr_gnt_d    = 1'b1;
          last_d      = WR;
          eng_start   = 1'b1;
          eng_frame   = make_frame(OPC_WRITE, SPI_ADDRBITS'(wr_addr_i), wr_data_i);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (eng_done) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= WR;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  // last_q names the port owning the transaction in flight until the next grant,
  // which cannot happen before the completion pulses have gone out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      busy_q     <= (state_d != IDLE);
      fin_q      <= eng_done;
      rd_valid_q <= fin_q && (last_q == RD);
      wr_done_q  <= fin_q && (last_q == WR);
      if (fin_q && (last_q == RD)) begin
        rd_data_q <= eng_rx;
      end
    end
  end

  spi_shift_engine u_engine (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (eng_start),
    .is_read_i (eng_is_read),
    .frame_i   (eng_frame),
    .so_i      (so_i),
    .cs_o      (cs_o),
    .sck_o     (sck_o),
    .si_o      (si_o),
    .rx_o      (eng_rx),
    .done_o    (eng_done)
  );

  assign rd_gnt_o   = rd_gnt_q;
  assign wr_gnt_o   = wr_gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign wr_done_o  = wr_done_q;
  assign rd_data_o  = rd_data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_sram_arbiter.sv
module tb_spi_sram_arbiter;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          so = 1'b0;
  logic          rd_gnt, rd_valid, wr_gnt, wr_done, busy, cs, sck, si;
  logic [7:0]    rd_data;

  spi_sram_arbiter #(.ADDRESSBITS(AW), .CS_GAP(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_req_i   (rd_req),
    .rd_addr_i  (rd_addr),
    .rd_gnt_o   (rd_gnt),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wr_req_i   (wr_req),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_gnt_o   (wr_gnt),
    .wr_done_o  (wr_done),
    .busy_o     (busy),
    .cs_o       (cs),
    .sck_o      (sck),
    .si_o       (si),
    .so_i       (so)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  logic [39:0] exp_frames[$];
  logic [7:0]  exp_rd[$];

  // SRAM model: capture si on sck rise, drive so for the data byte of reads
  logic [7:0]  sram_byte = 8'h00;
  logic [39:0] cap = '0;
  int          nb = 0;
  initial forever begin
    @(negedge cs or posedge sck);
    if (sck) begin
      cap = {cap[38:0], si};
      if (nb >= 32 && nb < 40) so = sram_byte[7-(nb-32)];
      nb = nb + 1;
    end else begin
      nb = 0;
    end
  end

  // monitor
  int cs_low = 0, cs_high = 0, gnt_cyc = 0;
  int n_wr_gnt = 0, n_valid = 0, n_done = 0;
  bit seen_tx = 1'b0;
  initial forever begin
    logic [39:0] ef;
    @(negedge clk);
    if (!rst_n) begin
      cs_low  = 0;
      cs_high = 0;
      seen_tx = 1'b0;
    end else begin
      if (!cs) begin
        if (cs_low == 0 && seen_tx) check_val("cs_gap_min", 64'(cs_high >= 2), 1);
        cs_low++;
      end else begin
        if (cs_low != 0) begin
          check_val("cs_low_cycles", cs_low, 80);
          if (exp_frames.size() > 0) begin
            ef = exp_frames.pop_front();
            check_val("frame_opcode", cap[39:32], ef[39:32]);
            check_val("frame_addr", cap[31:8], ef[31:8]);
            check_val("frame_data", cap[7:0], ef[7:0]);
          end else begin
            check_val("frame_unexpected", 1, 0);
          end
          seen_tx = 1'b1;
          cs_high = 0;
        end
        cs_low = 0;
        cs_high++;
      end
      if (rd_gnt || wr_gnt) gnt_cyc = cyc;
      if (wr_gnt) n_wr_gnt++;
      if (wr_done) begin
        n_done++;
        check_val("wr_latency", cyc - gnt_cyc, 81);
      end
      if (rd_valid) begin
        n_valid++;
        check_val("rd_latency", cyc - gnt_cyc, 81);
        if (exp_rd.size() > 0) check_val("rd_data", rd_data, exp_rd.pop_front());
        else check_val("rd_unexpected", 1, 0);
      end
    end
  end

  // sel: 0 rd_gnt, 1 wr_gnt, 2 rd_valid, 3 wr_done, 4 idle, other: any gnt
  task automatic wait_for(input int sel, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = rd_gnt;
        1: hit = wr_gnt;
        2: hit = rd_valid;
        3: hit = wr_done;
        4: hit = !busy;
        default: hit = rd_gnt | wr_gnt;
      endcase
    end
    if (!hit) check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    exp_frames.push_back({8'h02, 5'd0, a, d});
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    wait_for(1, "wr_gnt");
    wr_req = 1'b0;
    wait_for(3, "wr_done");
    wait_for(4, "wr_idle");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, d0, g0, busy_cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cs", cs, 1);
    check_val("rst_sck", sck, 0);
    check_val("rst_si", si, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rd_data", rd_data, 0);
    check_val("rst_pulses", {rd_gnt, wr_gnt, rd_valid, wr_done}, 0);
    rst_n = 1'b1;

    // single write
    do_write(19'h12345, 8'hA5);

    // single read, data held afterwards
    sram_byte = 8'h3C;
    exp_frames.push_back({8'h03, 5'd0, 19'h7FFFF, 8'h00});
    exp_rd.push_back(8'h3C);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 19'h7FFFF;
    wait_for(0, "t2_gnt");
    rd_req = 1'b0;
    wait_for(2, "t2_valid");
    repeat (10) @(negedge clk);
    check_val("t2_rd_hold", rd_data, 8'h3C);
    wait_for(4, "t2_idle");

    // both requests from reset release: rd, wr, rd
    rst_n = 1'b0;
    @(negedge clk);
    rd_req = 1'b1;
    wr_req = 1'b1;
    rd_addr = 19'h00042;
    wr_addr = 19'h40000;
    wr_data = 8'hC3;
    sram_byte = 8'h5A;
    exp_frames.push_back({8'h03, 5'd0, 19'h00042, 8'h00});
    exp_frames.push_back({8'h02, 5'd0, 19'h40000, 8'hC3});
    exp_frames.push_back({8'h03, 5'd0, 19'h00042, 8'h00});
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'h5A);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(5, "t3_gnt");
      check_val("t3_order_wr", wr_gnt, 64'(k == 1));
      check_val("t3_order_rd", rd_gnt, 64'(k != 1));
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    wait_for(2, "t3_valid");
    wait_for(4, "t3_idle");

    // reset during address bit 10
    exp_frames.push_back({8'h03, 5'd0, 19'h2AAAA, 8'h00});
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 19'h2AAAA;
    for (int i = 0; i < 300 && nb != 19; i++) @(negedge clk);
    check_val("t4_reach_bit10", nb, 19);
    snap = n_valid + n_done;
    rst_n = 1'b0;
    rd_req = 1'b0;
    #1;
    check_val("t4_cs_abort", cs, 1);
    check_val("t4_sck_abort", sck, 0);
    exp_frames.delete();
    exp_rd.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_val("t4_no_pulse", n_valid + n_done, snap);
    d0 = n_done;
    do_write(19'h00ABC, 8'h5E);
    check_val("t4_fresh_write", n_done - d0, 1);

    // write request held one cycle past its grant
    g0 = n_wr_gnt;
    d0 = n_done;
    exp_frames.push_back({8'h02, 5'd0, 19'h55555, 8'h0F});
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = 19'h55555;
    wr_data = 8'h0F;
    wait_for(1, "t5_gnt");
    busy_cnt = 0;
    for (int i = 0; i < 300 && busy; i++) begin
      busy_cnt++;
      @(negedge clk);
      if (i == 0) wr_req = 1'b0;
    end
    check_val("t5_busy_cycles", busy_cnt, 82);
    repeat (100) @(negedge clk);
    check_val("t5_one_gnt", n_wr_gnt - g0, 1);
    check_val("t5_one_done", n_done - d0, 1);
    check_val("sb_frames_empty", exp_frames.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
